// File: rtl/reg_dump_reader.sv
// Debug read-out engine: sweeps RegisterFile read addresses 0..NUM_REGS-1 and streams each word
// on a valid/ready port. Optional trailing checksum word when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] ReadReg,
  input  logic [DATA_W-1:0] ReadData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutIndex,
  output logic              OutLast,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
`ifdef REG_DUMP_CHECKSUM_EN
    CSUM = 3'd4,
`endif
    DONE = 3'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            stateR, stateNext;
  logic [ADDR_W-1:0] idxR, idxNext;
  logic              outValidR, outValidNext;
  logic [DATA_W-1:0] outDataR, outDataNext;
  logic [ADDR_W-1:0] outIndexR, outIndexNext;
  logic              outLastR, outLastNext;
  logic              busyR, busyNext;
  logic              doneR, doneNext;
  logic              transferS;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sumR, sumNext;
`endif

  assign transferS = outValidR && OutReady;

  // Next-state and next-output computation; every register's next value is decided here.
  always_comb begin
    stateNext    = stateR;
    idxNext      = idxR;
    outValidNext = outValidR;
    outDataNext  = outDataR;
    outIndexNext = outIndexR;
    outLastNext  = outLastR;
`ifdef REG_DUMP_CHECKSUM_EN
    sumNext      = sumR;
`endif
    case (stateR)
      IDLE: begin
        if (Start) begin
          idxNext   = {ADDR_W{1'b0}};
          stateNext = READ;
`ifdef REG_DUMP_CHECKSUM_EN
          sumNext   = {DATA_W{1'b0}};
`endif
        end else begin
          stateNext = IDLE;
        end
      end
      READ: begin
        outDataNext  = ReadData;
        outIndexNext = idxR;
        outValidNext = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        // The checksum word carries OutLast, so the final register does not.
        outLastNext  = 1'b0;
        sumNext      = sumR + ReadData;
`else
        outLastNext  = (idxR == LAST_IDX);
`endif
        stateNext    = SEND;
      end
      SEND: begin
        if (transferS) begin
          outValidNext = 1'b0;
          if (idxR == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
            // sumR already includes the last captured word, so load it directly.
            stateNext    = CSUM;
            outValidNext = 1'b1;
            outDataNext  = sumR;
            outIndexNext = {ADDR_W{1'b0}};
            outLastNext  = 1'b1;
`else
            stateNext    = DONE;
`endif
          end else begin
            idxNext   = idxR + ADDR_W'(1);
            stateNext = READ;
          end
        end else begin
          stateNext = SEND;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (transferS) begin
          outValidNext = 1'b0;
          stateNext    = DONE;
        end else begin
          stateNext = CSUM;
        end
      end
`endif
      DONE: begin
        idxNext   = {ADDR_W{1'b0}};
        stateNext = IDLE;
      end
      default: begin
        idxNext      = {ADDR_W{1'b0}};
        outValidNext = 1'b0;
        stateNext    = IDLE;
      end
    endcase
    busyNext = (stateNext != IDLE);
    doneNext = (stateNext == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      stateR    <= IDLE;
      idxR      <= {ADDR_W{1'b0}};
      outValidR <= 1'b0;
      outDataR  <= {DATA_W{1'b0}};
      outIndexR <= {ADDR_W{1'b0}};
      outLastR  <= 1'b0;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      sumR      <= {DATA_W{1'b0}};
`endif
    end else begin
      stateR    <= stateNext;
      idxR      <= idxNext;
      outValidR <= outValidNext;
      outDataR  <= outDataNext;
      outIndexR <= outIndexNext;
      outLastR  <= outLastNext;
      busyR     <= busyNext;
      doneR     <= doneNext;
`ifdef REG_DUMP_CHECKSUM_EN
      sumR      <= sumNext;
`endif
    end
  end

  assign ReadReg  = idxR;
  assign OutValid = outValidR;
  assign OutData  = outDataR;
  assign OutIndex = outIndexR;
  assign OutLast  = outLastR;
  assign Busy     = busyR;
  assign Done     = doneR;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: stimulus pushes expected words, a negedge monitor pops
// and compares on every transfer. Define REG_DUMP_CHECKSUM_EN to also exercise the checksum word.
module tb_reg_dump_reader;

  localparam int NREG = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int WORDS   = NREG + 1;
  localparam int DONE_AT = 2 * NREG + 1;
`else
  localparam int WORDS   = NREG;
  localparam int DONE_AT = 2 * NREG;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  i;
    logic        l;
  } word_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        OutReady = 1'b1;
  logic [4:0]  ReadReg;
  logic [31:0] ReadData;
  logic        OutValid, OutLast, Busy, Done;
  logic [31:0] OutData;
  logic [4:0]  OutIndex;

  logic [31:0] rf [NREG];
  word_t       expQ [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          xferCount = 0;
  int          doneCount = 0;
  int          doneCyc = 0;
  int          prevXferCyc = -1;
  bit          gapEn = 1'b0;
  bit          holdPending = 1'b0;
  logic [31:0] holdD;
  logic [4:0]  holdI;
  logic        holdL;

  assign ReadData = rf[ReadReg];

  reg_dump_reader #(.NUM_REGS(NREG), .ADDR_W(5), .DATA_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ReadReg(ReadReg), .ReadData(ReadData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutIndex(OutIndex),
    .OutLast(OutLast), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each transfer and checks held words stay stable.
  always @(negedge CLK) begin
    if (Reset) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        chk("hold_valid", {63'd0, OutValid}, 64'd1);
        chk("hold_word", {26'd0, OutData, OutIndex, OutLast}, {26'd0, holdD, holdI, holdL});
      end
      holdPending = OutValid && !OutReady;
      holdD = OutData;
      holdI = OutIndex;
      holdL = OutLast;
      if (OutValid && OutReady) begin
        if (expQ.size() == 0) begin
          chk("unexpected_word", {26'd0, OutData, OutIndex, OutLast}, 64'd0);
          if (OutData == 32'd0 && OutIndex == 5'd0 && !OutLast) begin
            errors++;
            $display("FAIL unexpected_word: got an extra all-zero word");
          end
        end else begin
          word_t e;
          e = expQ.pop_front();
          chk($sformatf("word_%0d", e.i), {26'd0, OutData, OutIndex, OutLast},
              {26'd0, e.d, e.i, e.l});
        end
        if (gapEn && prevXferCyc >= 0) chk("xfer_gap", 64'(cyc - prevXferCyc), 64'd2);
        prevXferCyc = cyc;
        xferCount++;
      end
      if (Done) begin
        doneCount++;
        doneCyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Expected sweep from the preloaded register image; csum is the hand-computed checksum.
  task automatic pushSweep(input logic [31:0] csum);
    word_t w;
    for (int i = 0; i < NREG; i++) begin
      w.d = rf[i];
      w.i = 5'(i);
`ifdef REG_DUMP_CHECKSUM_EN
      w.l = 1'b0;
`else
      w.l = (i == NREG - 1);
`endif
      expQ.push_back(w);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    w.d = csum;
    w.i = 5'd0;
    w.l = 1'b1;
    expQ.push_back(w);
`else
    w.d = csum;
`endif
  endtask

  task automatic pulseStart(output int startCyc);
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    startCyc = cyc;
  endtask

  task automatic waitDone(input bit toggle);
    int d0;
    int n;
    d0 = doneCount;
    n = 0;
    while (doneCount == d0 && n < 400) begin
      tick(1);
      n++;
      if (doneCount == d0 && toggle) Start = Done ? 1'b1 : ~Start;
    end
    Start = 1'b0;
    chk("done_timeout", {63'd0, doneCount == d0}, 64'd0);
  endtask

  task automatic waitRead(input logic [4:0] idx);
    int n;
    n = 0;
    while (!(ReadReg == idx && Busy && !OutValid) && n < 200) begin
      tick(1);
      n++;
    end
    chk("wait_read_timeout", {63'd0, n >= 200}, 64'd0);
  endtask

  task automatic checkIdle(input string name);
    chk(name, {16'd0, ReadReg, OutValid, OutData, OutIndex, OutLast, Busy, Done}, 64'd0);
  endtask

  initial begin
    int s;
    int x0;
    int d0;
    for (int i = 0; i < NREG; i++) rf[i] = 32'(i);
    tick(3);
    checkIdle("reset_state");
    Reset = 1'b0;
    tick(2);
    checkIdle("idle_state");

    // 1: full sweep with OutReady high, 2 cycles/word
    pushSweep(32'h000001F0);
    gapEn = 1'b1;
    prevXferCyc = -1;
    x0 = xferCount;
    d0 = doneCount;
    pulseStart(s);
    chk("read_cycle_valid", {62'd0, Busy, OutValid}, 64'd2);
    tick(1);
    chk("first_valid", {58'd0, OutValid, OutIndex}, 64'h20);
    waitDone(1'b0);
    chk("done_latency", 64'(doneCyc - s), 64'(DONE_AT));
    chk("idle_after_done", {62'd0, Busy, Done}, 64'd0);
    chk("sweep1_count", 64'(xferCount - x0), 64'(WORDS));
    chk("sweep1_done_pulses", 64'(doneCount - d0), 64'd1);
    gapEn = 1'b0;

    // 2: back-pressure on index 7
    pushSweep(32'h000001F0);
    x0 = xferCount;
    pulseStart(s);
    waitRead(5'd7);
    OutReady = 1'b0;
    tick(5);
    chk("stall_word7", {26'd0, OutValid, OutData[23:0], OutIndex}, {26'd0, 1'b1, 24'd7, 5'd7});
    OutReady = 1'b1;
    waitDone(1'b0);
    chk("sweep2_count", 64'(xferCount - x0), 64'(WORDS));
    chk("sweep2_queue_empty", 64'(expQ.size()), 64'd0);

    // 3: Start toggled throughout and held in DONE
    pushSweep(32'h000001F0);
    x0 = xferCount;
    d0 = doneCount;
    pulseStart(s);
    waitDone(1'b1);
    tick(4);
    chk("sweep3_count", 64'(xferCount - x0), 64'(WORDS));
    chk("sweep3_done_pulses", 64'(doneCount - d0), 64'd1);
    chk("sweep3_idle", {63'd0, Busy}, 64'd0);

    // 4: Reset in SEND at index 12, then a fresh sweep from index 0
    pushSweep(32'h000001F0);
    pulseStart(s);
    waitRead(5'd12);
    OutReady = 1'b0;
    tick(1);
    chk("send12", {58'd0, OutValid, OutIndex}, {58'd0, 1'b1, 5'd12});
    Reset = 1'b1;
    expQ.delete();
    tick(1);
    checkIdle("mid_sweep_reset");
    Reset = 1'b0;
    OutReady = 1'b1;
    pushSweep(32'h000001F0);
    x0 = xferCount;
    pulseStart(s);
    waitDone(1'b0);
    chk("sweep4_count", 64'(xferCount - x0), 64'(WORDS));

    // 6: register 5 rewritten before its READ cycle
    rf[5] = 32'hDEAD;
    pushSweep(32'h000001F0 - 32'd5 + 32'hDEAD);
    rf[5] = 32'd5;
    pulseStart(s);
    waitRead(5'd3);
    rf[5] = 32'hDEAD;
    waitDone(1'b0);
    rf[5] = 32'd5;
    chk("sweep6_queue_empty", 64'(expQ.size()), 64'd0);

`ifdef REG_DUMP_CHECKSUM_EN
    // 5: checksum wrap-around
    for (int i = 1; i < NREG; i++) rf[i] = 32'hFFFFFFFF;
    pushSweep(32'hFFFFFFE1);
    pulseStart(s);
    waitDone(1'b0);
    chk("sweep5_queue_empty", 64'(expQ.size()), 64'd0);
`endif

    tick(2);
    chk("final_idle", {62'd0, Busy, OutValid}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
